// File: rtl/pipe_exec_unit.sv
// Two-stage register file + ALU execution unit: one op issued per cycle, result and writeback one edge later.
// No backpressure; define ALU_FORWARD_EN to bypass the EX result into dependent ID operands.
module pipe_exec_unit #(
  parameter int N    = 32,
  parameter int NREG = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [3:0]              op,
  input  logic [$clog2(NREG)-1:0] raA,
  input  logic [$clog2(NREG)-1:0] raB,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic                    wen,
  input  logic                    init_we,
  input  logic [$clog2(NREG)-1:0] init_wa,
  input  logic [N-1:0]            init_wd,
  input  logic [$clog2(NREG)-1:0] dbg_ra,
  output logic [N-1:0]            dbg_rd,
  output logic                    out_valid,
  output logic [N-1:0]            result,
  output logic                    zero,
  output logic                    illegal
);

  localparam int AW = $clog2(NREG);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [N-1:0]  regs [NREG];

  logic          ex_vld;
  logic [3:0]    ex_op;
  logic [AW-1:0] ex_wa;
  logic          ex_wen;
  logic [N-1:0]  ex_a;
  logic [N-1:0]  ex_b;

  logic [N-1:0]  alu_res;
  logic          alu_ok;
  logic          wb_en;
  logic [N-1:0]  opnd_a;
  logic [N-1:0]  opnd_b;

  // ALU on the EX operands
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (ex_op)
      OP_AND:  alu_res = ex_a & ex_b;
      OP_OR:   alu_res = ex_a | ex_b;
      OP_ADD:  alu_res = ex_a + ex_b;
      OP_SUB:  alu_res = ex_a - ex_b;
      OP_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(ex_a) < $signed(ex_b))};
      OP_NOR:  alu_res = ~(ex_a | ex_b);
      default: alu_ok  = 1'b0;
    endcase
  end

  assign wb_en = ex_vld && ex_wen && alu_ok && (ex_wa != '0);

`ifdef ALU_FORWARD_EN
  assign opnd_a = (wb_en && (ex_wa == raA)) ? alu_res : regs[raA];
  assign opnd_b = (wb_en && (ex_wa == raB)) ? alu_res : regs[raB];
`else
  assign opnd_a = regs[raA];
  assign opnd_b = regs[raB];
`endif

  assign dbg_rd = regs[dbg_ra];

  // ID -> EX pipeline register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_vld <= 1'b0;
      ex_op  <= '0;
      ex_wa  <= '0;
      ex_wen <= 1'b0;
      ex_a   <= '0;
      ex_b   <= '0;
    end else begin
      ex_vld <= in_valid;
      if (in_valid) begin
        ex_op  <= op;
        ex_wa  <= wa;
        ex_wen <= wen;
        ex_a   <= opnd_a;
        ex_b   <= opnd_b;
      end
    end
  end

  // Register file; reg 0 is never written so it always reads 0.
  // Writeback is assigned last so it wins a same-address collision with init.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (init_we && (init_wa != '0)) regs[init_wa] <= init_wd;
      if (wb_en) regs[ex_wa] <= alu_res;
    end
  end

  // Retired-op outputs; result/zero/illegal hold through bubbles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= ex_vld;
      if (ex_vld) begin
        result  <= alu_res;
        zero    <= (alu_res == '0);
        illegal <= !alu_ok;
      end
    end
  end

endmodule

// File: tb/tb_pipe_exec_unit.sv
// Bench for pipe_exec_unit: directed vector table, multi-cycle corner sequences, randomized run vs reference model.
module tb_pipe_exec_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  op = '0;
  logic [4:0]  raA = '0, raB = '0, wa = '0;
  logic        wen = 1'b0;
  logic        init_we = 1'b0;
  logic [4:0]  init_wa = '0;
  logic [31:0] init_wd = '0;
  logic [4:0]  dbg_ra = '0;
  logic [31:0] dbg_rd;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  pipe_exec_unit #(.N(32), .NREG(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .op(op),
    .raA(raA), .raB(raB), .wa(wa), .wen(wen),
    .init_we(init_we), .init_wa(init_wa), .init_wd(init_wd),
    .dbg_ra(dbg_ra), .dbg_rd(dbg_rd),
    .out_valid(out_valid), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic        wen;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
    logic        exp_wr;
  } vec_t;

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wa;
    logic        wen;
  } ex_t;

  vec_t        tbl [13];
  logic [31:0] mregs [32];
  logic [3:0]  oplist [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic init_wr(input logic [4:0] a, input logic [31:0] d);
    init_we = 1'b1; init_wa = a; init_wd = d;
    tick();
    init_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] w, input logic we);
    in_valid = 1'b1; op = o; raA = ra; raB = rb; wa = w; wen = we;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rdreg(input logic [4:0] a, output logic [31:0] v);
    dbg_ra = a;
    #1;
    v = dbg_rd;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Spec-level ALU: returns {illegal, result}
  function automatic logic [32:0] alu_ref(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b0110: return {1'b0, a - b};
      4'b0111: return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
      4'b1100: return {1'b0, ~(a | b)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    logic [32:0] alu;
    logic        wb;
    ex_t         ex, nex;

    tbl[0]  = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3, 1'b1, 32'h00F0_1200, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0001, 32'd2, 32'd4, 5'd4, 1'b1, 32'd6, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{4'b0010, 32'd2, 32'd4, 5'd3, 1'b1, 32'd6, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{4'b0010, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{4'b0110, 32'd2, 32'd4, 5'd6, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{4'b0110, 32'd5, 32'd3, 5'd0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0111, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{4'b0111, 32'd2, 32'hFFFF_FFF9, 5'd5, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd6, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{4'b1100, 32'd2, 32'd4, 5'd4, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{4'b1110, 32'd2, 32'd4, 5'd3, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{4'b0010, 32'd2, 32'd4, 5'd3, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{4'b0110, 32'd9, 32'd9, 5'd4, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1};

    oplist[0] = 4'b0000; oplist[1] = 4'b0001; oplist[2] = 4'b0010; oplist[3] = 4'b0110;
    oplist[4] = 4'b0111; oplist[5] = 4'b1100; oplist[6] = 4'b1110;

    // Reset state
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rdreg(i[4:0], v);
      chk($sformatf("rst_reg%0d", i), v, 32'd0);
    end

    // Directed table: r1=a, r2=b, reg[wa]=sentinel, issue op, check one edge later
    for (int i = 0; i < 13; i++) begin
      tick();
      init_wr(5'd1, tbl[i].a);
      init_wr(5'd2, tbl[i].b);
      init_wr(tbl[i].wa, 32'hDEAD_0000 + i);
      issue(tbl[i].op, 5'd1, 5'd2, tbl[i].wa, tbl[i].wen);
      chk($sformatf("v%0d_no_early_valid", i), {31'd0, out_valid}, 32'd0);
      tick();
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), result, tbl[i].exp_res);
      chk($sformatf("v%0d_zero", i), {31'd0, zero}, {31'd0, tbl[i].exp_zero});
      chk($sformatf("v%0d_illegal", i), {31'd0, illegal}, {31'd0, tbl[i].exp_ill});
      rdreg(tbl[i].wa, v);
      chk($sformatf("v%0d_reg", i), v,
          (tbl[i].wa == 5'd0) ? 32'd0 : (tbl[i].exp_wr ? tbl[i].exp_res : 32'hDEAD_0000 + i));
      tick();
      chk($sformatf("v%0d_valid_drops", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back dependency: r4 = r3 + r3 right after r3 = r1 + r2
    do_reset();
    init_wr(5'd1, 32'd2);
    init_wr(5'd2, 32'd4);
    issue(4'b0010, 5'd1, 5'd2, 5'd3, 1'b1);
    issue(4'b0010, 5'd3, 5'd3, 5'd4, 1'b1);
    chk("dep_first_result", result, 32'd6);
    tick();
    rdreg(5'd4, v);
`ifdef ALU_FORWARD_EN
    chk("dep_second_result", result, 32'd12);
    chk("dep_r4", v, 32'd12);
`else
    chk("dep_second_result", result, 32'd0);
    chk("dep_r4", v, 32'd0);
`endif

    // Init/writeback collision on r7: writeback wins
    issue(4'b0010, 5'd1, 5'd2, 5'd7, 1'b1);
    init_wr(5'd7, 32'h0000_0055);
    rdreg(5'd7, v);
    chk("collide_r7", v, 32'd6);
    // Different addresses on the same edge: both land
    issue(4'b0001, 5'd1, 5'd2, 5'd7, 1'b1);
    init_wr(5'd5, 32'h0000_00AA);
    rdreg(5'd7, v);
    chk("both_r7", v, 32'd6);
    rdreg(5'd5, v);
    chk("both_r5", v, 32'h0000_00AA);

    // Reset while an op sits in EX and a result is showing
    issue(4'b0010, 5'd1, 5'd2, 5'd3, 1'b1);
    issue(4'b0110, 5'd2, 5'd1, 5'd4, 1'b1);
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_result", result, 32'd0);
    chk("mid_zero", {31'd0, zero}, 32'd0);
    chk("mid_illegal", {31'd0, illegal}, 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mid_post_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      rdreg(i[4:0], v);
      chk($sformatf("mid_reg%0d", i), v, 32'd0);
    end

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    ex = '{1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0};
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      op       = oplist[$urandom_range(0, 6)];
      raA      = 5'($urandom_range(0, 7));
      raB      = 5'($urandom_range(0, 7));
      wa       = 5'($urandom_range(0, 7));
      wen      = ($urandom_range(0, 4) != 0);
      init_we  = ($urandom_range(0, 3) == 0);
      init_wa  = 5'($urandom_range(0, 7));
      init_wd  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      dbg_ra   = 5'($urandom_range(0, 7));

      alu = alu_ref(ex.op, ex.a, ex.b);
      wb  = ex.v && ex.wen && !alu[32] && (ex.wa != 5'd0);
      nex = '{in_valid, op, mregs[raA], mregs[raB], wa, wen};
`ifdef ALU_FORWARD_EN
      if (wb && ex.wa == raA) nex.a = alu[31:0];
      if (wb && ex.wa == raB) nex.b = alu[31:0];
`endif
      if (init_we && init_wa != 5'd0) mregs[init_wa] = init_wd;
      if (wb) mregs[ex.wa] = alu[31:0];

      tick();
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, ex.v});
      if (ex.v) begin
        chk("rnd_result", result, alu[31:0]);
        chk("rnd_zero", {31'd0, zero}, {31'd0, (alu[31:0] == 32'd0)});
        chk("rnd_illegal", {31'd0, illegal}, {31'd0, alu[32]});
      end
      chk("rnd_dbg_rd", dbg_rd, mregs[dbg_ra]);
      ex = nex;
    end
    in_valid = 1'b0;
    init_we  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
